wb_timer_slave: RTL
===================

// Module: wb_timer_slave
// PURPOSE
//  Wishbone B4 classic responder on the core data bus holding the machine timer (mtime/mtimecmp).
//  Drives core.timer_irq, level-high, while mtime >= mtimecmp and the timer is enabled.
//  Word-addressed register file; one-cycle registered ack; byte selects honoured.
// PARAMETERS
//  ADDR_WIDTH   32   width of adr_i; only adr_i[4:2] decoded, upper bits ignored (interconnect selects)
//  MTIME_RST    0    64-bit reset value of mtime
//  CTRL_RST     1'b1 reset value of CTRL.EN
// PORTS
//  clk         in   1           clock, single domain
//  rst         in   1           synchronous reset, active-high
//  cyc_i       in   1           Wishbone cycle
//  stb_i       in   1           Wishbone strobe
//  we_i        in   1           1 = write
//  adr_i       in   ADDR_WIDTH  byte address
//  sel_i       in   4           byte lane enables
//  dat_i       in   32          write data
//  dat_o       out  32          read data, valid with ack_o
//  ack_o       out  1           transfer acknowledge
//  err_o       out  1           error acknowledge (unmapped offset)
//  timer_irq   out  1           machine timer interrupt to core
// BEHAVIOUR
//  Reset: ack_o=0, err_o=0, dat_o=0, timer_irq=0, mtime=MTIME_RST, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF,
//   CTRL.EN=CTRL_RST, PRESC=0. Reset mid-transfer drops ack_o/err_o the next edge; no write commits.
//  Map (adr_i[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN), 5 PRESC;
//   6,7 unmapped.
//  Handshake FSM: IDLE -> RESP when cyc_i&stb_i; RESP asserts ack_o (or err_o) one cycle, then IDLE.
//   Latency exactly 1 cycle; never ack in two consecutive cycles; a request is sampled only in IDLE.
//   Dropping cyc_i while in RESP: the response still completes; the write already committed.
//  Writes commit at the sampling edge (IDLE, request seen); per lane: reg[8k+7:8k] <= dat_i when sel_i[k].
//  Reads: dat_o registered from the sampled address; dat_o=0 on err; bits 31:1 of CTRL read 0.
//  Unmapped offset: err_o instead of ack_o, no state change, dat_o=0.
//  Counting: when EN=1 and tick=1, mtime <= mtime+1 (64-bit, wraps FFFF..FF -> 0). EN=0 holds mtime.
//  Simultaneous bus write and increment to mtime: the write wins for written lanes; unwritten lanes
//   take the incremented value. The software writes LO then HI; no cross-half carry protection.
//  timer_irq registered: timer_irq <= EN & (mtime >= mtimecmp) using post-update values; unsigned
//   64-bit compare. The irq clears the cycle after mtimecmp is raised above mtime.
// CONFIGURATION
//  TIMER_PRESCALER_EN defined: 32-bit prescale counter; tick=1 when count==PRESC, then count<=0,
//   else count+1 (PRESC=0 gives one tick every clock). A write to PRESC clears the count.
//   Offset 5 is mapped.
//  Undefined: tick=1 every clock; offset 5 is unmapped (err_o); no prescale logic.
// STRUCTURE
//  global_pkg: typedef enum logic [2:0] timer_reg_t {TMR_MTIME_LO..TMR_PRESC};
//   typedef enum {TMR_IDLE, TMR_RESP} timer_bus_state_t; localparam MTIMECMP_RST.
//  Sub-module timer_counter64: EN, tick, lane-masked 64-bit load, wrap, compare output. Bus FSM and
//   decode stay in the top.
// TESTING
//  Reset then read 0x0/0x8 -> ack after 1 cycle, dat_o=0x0 and 0xFFFF_FFFF; timer_irq=0 throughout.
//  EN=1, write MTIMECMP_LO=5, MTIMECMP_HI=0, MTIME=0 -> timer_irq rises exactly the cycle after
//   mtime reaches 5; write MTIMECMP_LO=100 -> timer_irq falls next cycle.
//  MTIME_HI=0xFFFF_FFFF, MTIME_LO=0xFFFF_FFFE -> wraps to 0 two ticks later; the HI read returns 0.
//  Write 0xAABBCCDD to MTIMECMP_LO with sel_i=4'b0101 (old 0x11223344) -> read back 0x11BB33DD.
//  Access to offset 0x18 -> err_o=1 and ack_o=0 for 1 cycle; no register changes; held stb_i gives
//   alternating response and idle cycles.
//  With TIMER_PRESCALER_EN, PRESC=3 -> mtime increments once per 4 clocks; without it, 0x14 -> err_o.

Source files
------------

// File: rtl/global_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | global_pkg : shared types and constants for the wb_timer_slave block     |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package global_pkg;

  typedef enum logic [2:0] {
    TMR_MTIME_LO    = 3'd0,
    TMR_MTIME_HI    = 3'd1,
    TMR_MTIMECMP_LO = 3'd2,
    TMR_MTIMECMP_HI = 3'd3,
    TMR_CTRL        = 3'd4,
    TMR_PRESC       = 3'd5
  } timer_reg_t;

  typedef enum logic [0:0] {
    TMR_IDLE = 1'b0,
    TMR_RESP = 1'b1
  } timer_bus_state_t;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = sel[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_counter64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_counter64 : 64-bit mtime/mtimecmp pair, lane-masked loads, irq     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module timer_counter64 import global_pkg::*; #(
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        tick_i,
  input  logic        irq_en_i,
  input  logic [7:0]  mtime_ld_sel_i,
  input  logic [7:0]  cmp_ld_sel_i,
  input  logic [31:0] ld_data_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        irq_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;
  logic [63:0] inc_val;
  logic [63:0] ld64;

  assign ld64 = {ld_data_i, ld_data_i};

  // Written lanes override the increment; untouched lanes keep counting.
  always_comb begin
    inc_val = (en_i && tick_i) ? mtime_q + 64'd1 : mtime_q;
    mtime_d = inc_val;
    cmp_d   = cmp_q;
    for (int k = 0; k < 8; k++) begin
      if (mtime_ld_sel_i[k]) mtime_d[8*k +: 8] = ld64[8*k +: 8];
      if (cmp_ld_sel_i[k])   cmp_d[8*k +: 8]   = ld64[8*k +: 8];
    end
    irq_d = irq_en_i && (mtime_d >= cmp_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= MTIME_RST;
      cmp_q   <= MTIMECMP_RST;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      irq_q   <= irq_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = cmp_q;
  assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: rtl/wb_timer_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_timer_slave : Wishbone B4 classic machine-timer responder (mtime/cmp) |
// | Revision       : 1.0   Option macro: TIMER_PRESCALER_EN                  |
// +--------------------------------------------------------------------------+
module wb_timer_slave import global_pkg::*; #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [63:0] MTIME_RST  = 64'd0,
  parameter logic        CTRL_RST   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  timer_irq
);

  timer_bus_state_t state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        en_q, en_d;
  logic [31:0] dat_q, dat_d;
  logic [2:0]  off;
  logic        req, mapped, wr, tick;
  logic [31:0] rd_data;
  logic [7:0]  mtime_ld_sel, cmp_ld_sel;
  logic [63:0] mtime, mtimecmp;
  logic        irq;
  logic        unused_adr;

  // Upper address bits are decoded by the interconnect.
  assign unused_adr = ^{adr_i[ADDR_WIDTH-1:5], adr_i[1:0]};
  assign off        = adr_i[4:2];
  assign req        = cyc_i && stb_i && (state_q == TMR_IDLE);
  assign wr         = req && we_i && mapped;

  always_comb begin
    mapped = 1'b0;
    case (off)
      TMR_MTIME_LO, TMR_MTIME_HI, TMR_MTIMECMP_LO, TMR_MTIMECMP_HI, TMR_CTRL: mapped = 1'b1;
`ifdef TIMER_PRESCALER_EN
      TMR_PRESC: mapped = 1'b1;
`endif
      default: mapped = 1'b0;
    endcase
  end

`ifdef TIMER_PRESCALER_EN
  logic [31:0] presc_q, presc_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic        presc_wr;

  always_comb begin
    presc_wr = wr && (off == TMR_PRESC);
    presc_d  = presc_wr ? lane_merge(presc_q, dat_i, sel_i) : presc_q;
    tick     = (pcnt_q == presc_q);
    pcnt_d   = (presc_wr || tick) ? 32'd0 : pcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 32'd0;
      pcnt_q  <= 32'd0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    rd_data = 32'd0;
    case (off)
      TMR_MTIME_LO:    rd_data = mtime[31:0];
      TMR_MTIME_HI:    rd_data = mtime[63:32];
      TMR_MTIMECMP_LO: rd_data = mtimecmp[31:0];
      TMR_MTIMECMP_HI: rd_data = mtimecmp[63:32];
      TMR_CTRL:        rd_data = {31'd0, en_q};
`ifdef TIMER_PRESCALER_EN
      TMR_PRESC:       rd_data = presc_q;
`endif
      default:         rd_data = 32'd0;
    endcase
  end

  // A request is only accepted in IDLE, so a held strobe alternates response and idle.
  always_comb begin
    state_d      = state_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    dat_d        = 32'd0;
    en_d         = en_q;
    mtime_ld_sel = 8'd0;
    cmp_ld_sel   = 8'd0;
    case (state_q)
      TMR_IDLE: begin
        if (cyc_i && stb_i) begin
          state_d = TMR_RESP;
          ack_d   = mapped;
          err_d   = !mapped;
          if (mapped && !we_i) dat_d = rd_data;
          if (wr) begin
            case (off)
              TMR_MTIME_LO:    mtime_ld_sel = {4'b0000, sel_i};
              TMR_MTIME_HI:    mtime_ld_sel = {sel_i, 4'b0000};
              TMR_MTIMECMP_LO: cmp_ld_sel   = {4'b0000, sel_i};
              TMR_MTIMECMP_HI: cmp_ld_sel   = {sel_i, 4'b0000};
              TMR_CTRL:        if (sel_i[0]) en_d = dat_i[0];
              default:         ;
            endcase
          end
        end
      end
      TMR_RESP: state_d = TMR_IDLE;
      default:  state_d = TMR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
      en_q    <= CTRL_RST;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
    end
  end

  timer_counter64 #(
    .MTIME_RST (MTIME_RST)
  ) u_counter (
    .clk            (clk),
    .rst            (rst),
    .en_i           (en_q),
    .tick_i         (tick),
    .irq_en_i       (en_d),
    .mtime_ld_sel_i (mtime_ld_sel),
    .cmp_ld_sel_i   (cmp_ld_sel),
    .ld_data_i      (dat_i),
    .mtime_o        (mtime),
    .mtimecmp_o     (mtimecmp),
    .irq_o          (irq)
  );

  assign dat_o     = dat_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign timer_irq = irq;

endmodule
`default_nettype wire
